// File: rtl/lsu_pkg.sv
// Shared types for the load/store stage: op codes, memory commands,
// stage states and small op-decode helpers.
package lsu_pkg;

    typedef enum logic [3:0] {
        OP_X   = 4'd0,
        OP_LB  = 4'd1,
        OP_LBU = 4'd2,
        OP_LH  = 4'd3,
        OP_LHU = 4'd4,
        OP_LW  = 4'd5,
        OP_LWU = 4'd6,
        OP_LD  = 4'd7,
        OP_SB  = 4'd8,
        OP_SH  = 4'd9,
        OP_SW  = 4'd10,
        OP_SD  = 4'd11
    } mem_op_e;

    localparam logic [1:0] CMD_NONE  = 2'd0;
    localparam logic [1:0] CMD_READ  = 2'd1;
    localparam logic [1:0] CMD_WRITE = 2'd2;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CHECK,
        S_REQ,
        S_WAIT_RD,
        S_OUT
    } state_e;

    function automatic logic is_load(input logic [3:0] op);
        return (op >= OP_LB) && (op <= OP_LD);
    endfunction

    function automatic logic is_store(input logic [3:0] op);
        return (op >= OP_SB) && (op <= OP_SD);
    endfunction

    // log2 of the access size in bytes
    function automatic logic [1:0] size_of(input logic [3:0] op);
        case (op)
            OP_LB, OP_LBU, OP_SB: return 2'd0;
            OP_LH, OP_LHU, OP_SH: return 2'd1;
            OP_LW, OP_LWU, OP_SW: return 2'd2;
            default:              return 2'd3;
        endcase
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Byte-lane steering for the load/store stage: store shift and mask,
// load shift and extension, misalignment detection.
module lsu_align
    import lsu_pkg::*;
#(
    parameter int XLEN = 32,
    localparam int MASK_W = XLEN / 8,
    localparam int OFF_W = $clog2(MASK_W),
    localparam int IW = $clog2(XLEN)
) (
    input  logic [3:0]        op,
    input  logic [OFF_W-1:0]  offset,
    input  logic [XLEN-1:0]   rs2,
    input  logic [XLEN-1:0]   rdata,
    output logic [XLEN-1:0]   wdata,
    output logic [MASK_W-1:0] wmask,
    output logic [XLEN-1:0]   rdata_ext,
    output logic              misaligned
);

    logic [1:0]        size;
    logic [IW-1:0]     bit_off;
    logic [MASK_W-1:0] base;
    logic [XLEN-1:0]   sh;
    logic [IW-1:0]     msb_idx;
    logic              sgn;
    logic              fill;
    logic              mis;
    logic              illegal;

    assign size    = size_of(op);
    assign bit_off = {offset, 3'b000};

    always_comb begin
        base    = '1;
        msb_idx = IW'(XLEN - 1);
        unique case (size)
            2'd0: begin
                base    = MASK_W'(1);
                msb_idx = IW'(7);
            end
            2'd1: begin
                base    = MASK_W'(3);
                msb_idx = IW'(15);
            end
            2'd2: begin
                base    = MASK_W'(15);
                msb_idx = IW'(31);
            end
            default: ;
        endcase
    end

    always_comb begin
        mis = 1'b0;
        unique case (size)
            2'd1:    mis = offset[0];
            2'd2:    mis = |offset[1:0];
            2'd3:    mis = |offset;
            default: mis = 1'b0;
        endcase
    end

    // doubleword ops and LWU do not exist on a 32-bit datapath
    assign illegal = (XLEN == 32)
                   && (op == OP_LD || op == OP_SD || op == OP_LWU);
    assign misaligned = (is_load(op) || is_store(op))
                      && (mis || illegal);

    assign wdata = rs2 << bit_off;
    assign wmask = is_store(op) ? (base << offset) : '1;

    assign sh   = rdata >> bit_off;
    assign sgn  = (op == OP_LB) || (op == OP_LH) || (op == OP_LW);
    assign fill = sgn & sh[msb_idx];

    always_comb begin
        rdata_ext = '0;
        for (int i = 0; i < XLEN; i++) begin
            rdata_ext[i] = (i <= int'(msb_idx)) ? sh[i] : fill;
        end
    end

endmodule

// File: rtl/lsu_stage.sv
// Memory-access pipeline stage between execute and writeback with
// valid/ready handshakes and a cmd/ready/rvalid data-memory port.
module lsu_stage
    import lsu_pkg::*;
#(
    parameter int XLEN = 32,
    parameter int ADDR_W = 32,
    localparam int MASK_W = XLEN / 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [XLEN-1:0]   in_pc,
    input  logic [XLEN-1:0]   in_rs2,
    input  logic [XLEN-1:0]   in_alu,
    input  logic [3:0]        in_mem_op,
    input  logic [3:0]        in_wb_sel,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [XLEN-1:0]   out_pc,
    output logic [XLEN-1:0]   out_alu,
    output logic [XLEN-1:0]   out_rdata,
    output logic [3:0]        out_wb_sel,
    output logic              out_exc,
    output logic [1:0]        mem_cmd,
    input  logic              mem_cmd_ready,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [XLEN-1:0]   mem_wdata,
    output logic [MASK_W-1:0] mem_wmask,
    input  logic [XLEN-1:0]   mem_rdata,
    input  logic              mem_rvalid
);

    localparam int OFF_W = $clog2(MASK_W);

    state_e            state_q, state_d;
    logic [3:0]        op_q, op_d;
    logic [XLEN-1:0]   pc_q, pc_d;
    logic [XLEN-1:0]   rs2_q, rs2_d;
    logic [XLEN-1:0]   alu_q, alu_d;
    logic [3:0]        wb_sel_q, wb_sel_d;
    logic              out_valid_q, out_valid_d;
    logic [XLEN-1:0]   out_pc_q, out_pc_d;
    logic [XLEN-1:0]   out_alu_q, out_alu_d;
    logic [XLEN-1:0]   out_rdata_q, out_rdata_d;
    logic [3:0]        out_wb_sel_q, out_wb_sel_d;
    logic              out_exc_q, out_exc_d;
    logic [1:0]        mem_cmd_q, mem_cmd_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [XLEN-1:0]   mem_wdata_q, mem_wdata_d;
    logic [MASK_W-1:0] mem_wmask_q, mem_wmask_d;

    logic [XLEN-1:0]   al_wdata;
    logic [XLEN-1:0]   al_rdata;
    logic [MASK_W-1:0] al_wmask;
    logic              al_mis;
    logic              accept;

    lsu_align #(.XLEN(XLEN)) u_align (
        .op         (op_q),
        .offset     (alu_q[OFF_W-1:0]),
        .rs2        (rs2_q),
        .rdata      (mem_rdata),
        .wdata      (al_wdata),
        .wmask      (al_wmask),
        .rdata_ext  (al_rdata),
        .misaligned (al_mis)
    );

    always_comb begin
        state_d      = state_q;
        op_d         = op_q;
        pc_d         = pc_q;
        rs2_d        = rs2_q;
        alu_d        = alu_q;
        wb_sel_d     = wb_sel_q;
        out_valid_d  = out_valid_q;
        out_pc_d     = out_pc_q;
        out_alu_d    = out_alu_q;
        out_rdata_d  = out_rdata_q;
        out_wb_sel_d = out_wb_sel_q;
        out_exc_d    = out_exc_q;
        mem_cmd_d    = mem_cmd_q;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;
        mem_wmask_d  = mem_wmask_q;

        in_ready = rst_n
                 && (state_q == S_IDLE || state_q == S_OUT)
                 && (!out_valid_q || out_ready);
        accept = in_valid && in_ready;

        unique case (state_q)
            S_IDLE, S_OUT: begin
                if (out_valid_q && out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = S_IDLE;
                end
                if (accept) begin
                    op_d     = in_mem_op;
                    pc_d     = in_pc;
                    rs2_d    = in_rs2;
                    alu_d    = in_alu;
                    wb_sel_d = in_wb_sel;
                    if (is_load(in_mem_op) || is_store(in_mem_op)) begin
                        state_d = S_CHECK;
                    end else begin
                        state_d      = S_OUT;
                        out_valid_d  = 1'b1;
                        out_pc_d     = in_pc;
                        out_alu_d    = in_alu;
                        out_rdata_d  = '1;
                        out_wb_sel_d = in_wb_sel;
                        out_exc_d    = 1'b0;
                    end
                end
            end
            S_CHECK: begin
                out_pc_d     = pc_q;
                out_alu_d    = alu_q;
                out_wb_sel_d = wb_sel_q;
                out_exc_d    = 1'b0;
                if (al_mis) begin
                    state_d     = S_OUT;
                    out_valid_d = 1'b1;
                    out_exc_d   = 1'b1;
                    out_rdata_d = '0;
                end else begin
                    state_d     = S_REQ;
                    mem_cmd_d   = is_store(op_q) ? CMD_WRITE : CMD_READ;
                    mem_addr_d  = {alu_q[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
                    mem_wdata_d = al_wdata;
                    mem_wmask_d = al_wmask;
                end
            end
            S_REQ: begin
                // rvalid in the accept cycle is deliberately ignored
                if (mem_cmd_ready) begin
                    mem_cmd_d = CMD_NONE;
                    if (is_store(op_q)) begin
                        state_d     = S_OUT;
                        out_valid_d = 1'b1;
                        out_rdata_d = '1;
                    end else begin
                        state_d = S_WAIT_RD;
                    end
                end
            end
            S_WAIT_RD: begin
                if (mem_rvalid) begin
                    state_d     = S_OUT;
                    out_valid_d = 1'b1;
                    out_rdata_d = al_rdata;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            op_q         <= '0;
            pc_q         <= '0;
            rs2_q        <= '0;
            alu_q        <= '0;
            wb_sel_q     <= '0;
            out_valid_q  <= 1'b0;
            out_pc_q     <= '0;
            out_alu_q    <= '0;
            out_rdata_q  <= '0;
            out_wb_sel_q <= '0;
            out_exc_q    <= 1'b0;
            mem_cmd_q    <= CMD_NONE;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            mem_wmask_q  <= '0;
        end else begin
            state_q      <= state_d;
            op_q         <= op_d;
            pc_q         <= pc_d;
            rs2_q        <= rs2_d;
            alu_q        <= alu_d;
            wb_sel_q     <= wb_sel_d;
            out_valid_q  <= out_valid_d;
            out_pc_q     <= out_pc_d;
            out_alu_q    <= out_alu_d;
            out_rdata_q  <= out_rdata_d;
            out_wb_sel_q <= out_wb_sel_d;
            out_exc_q    <= out_exc_d;
            mem_cmd_q    <= mem_cmd_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            mem_wmask_q  <= mem_wmask_d;
        end
    end

    assign out_valid  = out_valid_q;
    assign out_pc     = out_pc_q;
    assign out_alu    = out_alu_q;
    assign out_rdata  = out_rdata_q;
    assign out_wb_sel = out_wb_sel_q;
    assign out_exc    = out_exc_q;
    assign mem_cmd    = mem_cmd_q;
    assign mem_addr   = mem_addr_q;
    assign mem_wdata  = mem_wdata_q;
    assign mem_wmask  = mem_wmask_q;

endmodule
